reg_writeback_queue: RTL and testbench

//  Writer-side client of the 32x32 register file write port (A3/WD3/WE3).

---
 rtl/reg_writeback_queue_if.sv | 24 ++
 rtl/reg_writeback_queue.sv | 116 +++++++++++
 tb/tb_reg_writeback_queue.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_if.sv
// Writeback queue bus: enqueue handshake from the writeback mux and the
// register-file write port (A3/WD3/WE3) driven by the queue.
interface reg_writeback_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  enq_valid;
    logic                  enq_ready;
    logic [ADDR_WIDTH-1:0] enq_addr;
    logic [DATA_WIDTH-1:0] enq_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output enq_valid, enq_addr, enq_data,
        input  enq_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  enq_valid, enq_addr, enq_data,
        output enq_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Register-file writeback FIFO with pending-write scoreboard for RAW hazards.
// Optional youngest-match data forwarding enabled by defining WBQ_FORWARD_EN.
module reg_writeback_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    RST,
    reg_writeback_queue_if.slave    bus,
    input  logic [ADDR_WIDTH-1:0]   chk_addr1,
    input  logic [ADDR_WIDTH-1:0]   chk_addr2,
    output logic                    hazard1,
    output logic                    hazard2,
    output logic [DATA_WIDTH-1:0]   fwd_data1,
    output logic [DATA_WIDTH-1:0]   fwd_data2,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [DEPTH-1:0]      set_mask_s;
    logic [DEPTH-1:0]      clr_mask_s;

    // Queue status and push/pop decisions; $zero writes complete the handshake but are not stored.
    always_comb begin
        full_s     = (count_r == CNT_W'(DEPTH));
        empty_s    = (count_r == {CNT_W{1'b0}});
        pop_s      = !empty_s;
        push_s     = bus.enq_valid && !full_s && (bus.enq_addr != {ADDR_WIDTH{1'b0}});
        set_mask_s = push_s ? (DEPTH'(1) << tail_r) : {DEPTH{1'b0}};
        clr_mask_s = pop_s  ? (DEPTH'(1) << head_r) : {DEPTH{1'b0}};
    end

    // Entry storage, pointers and occupancy; reset discards every pending write.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= {ADDR_WIDTH{1'b0}};
                data_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                addr_r[tail_r] <= bus.enq_addr;
                data_r[tail_r] <= bus.enq_data;
                tail_r         <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            valid_r <= (valid_r | set_mask_s) & ~clr_mask_s;
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Write port and status driven purely from flops; idle port shows zeros.
    always_comb begin
        bus.enq_ready = !full_s;
        bus.wr_en     = !empty_s;
        bus.wr_addr   = empty_s ? {ADDR_WIDTH{1'b0}} : addr_r[head_r];
        bus.wr_data   = empty_s ? {DATA_WIDTH{1'b0}} : data_r[head_r];
        count         = count_r;
    end

    // Scoreboard lookup: any valid entry, including the head popping this cycle.
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hazard1 = hazard1 | (valid_r[i] && (addr_r[i] == chk_addr1));
            hazard2 = hazard2 | (valid_r[i] && (addr_r[i] == chk_addr2));
        end
        hazard1 = hazard1 && (chk_addr1 != {ADDR_WIDTH{1'b0}});
        hazard2 = hazard2 && (chk_addr2 != {ADDR_WIDTH{1'b0}});
    end

`ifdef WBQ_FORWARD_EN
    logic [PTR_W-1:0] age_idx_s;
    logic             in_q_s;

    // Walk entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_data1 = {DATA_WIDTH{1'b0}};
        fwd_data2 = {DATA_WIDTH{1'b0}};
        age_idx_s = {PTR_W{1'b0}};
        in_q_s    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            age_idx_s = head_r + PTR_W'(k);
            in_q_s    = (CNT_W'(k) < count_r) && valid_r[age_idx_s];
            fwd_data1 = (in_q_s && (chk_addr1 != {ADDR_WIDTH{1'b0}}) && (addr_r[age_idx_s] == chk_addr1))
                        ? data_r[age_idx_s] : fwd_data1;
            fwd_data2 = (in_q_s && (chk_addr2 != {ADDR_WIDTH{1'b0}}) && (addr_r[age_idx_s] == chk_addr2))
                        ? data_r[age_idx_s] : fwd_data2;
        end
    end
`else
    assign fwd_data1 = {DATA_WIDTH{1'b0}};
    assign fwd_data2 = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench: directed steps plus random traffic against a queue-based reference model.
module tb_reg_writeback_queue;
    logic        clk = 1'b0;
    logic        RST;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        hazard1;
    logic        hazard2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    reg_writeback_queue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus();

    reg_writeback_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
        .clk       (clk),
        .RST       (RST),
        .bus       (bus),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against what the pending-write list implies right now.
    task automatic check_model();
        logic        h1, h2;
        logic [31:0] f1, f2;
        h1 = 1'b0; h2 = 1'b0; f1 = 32'h0; f2 = 32'h0;
        foreach (mq[i]) begin
            if (chk_addr1 != 5'd0 && mq[i].a == chk_addr1) begin h1 = 1'b1; f1 = mq[i].d; end
            if (chk_addr2 != 5'd0 && mq[i].a == chk_addr2) begin h2 = 1'b1; f2 = mq[i].d; end
        end
`ifndef WBQ_FORWARD_EN
        f1 = 32'h0; f2 = 32'h0;
`endif
        check("wr_en",     {31'd0, bus.wr_en},     {31'd0, mq.size() != 0});
        check("wr_addr",   {27'd0, bus.wr_addr},   (mq.size() != 0) ? {27'd0, mq[0].a} : 32'h0);
        check("wr_data",   bus.wr_data,            (mq.size() != 0) ? mq[0].d : 32'h0);
        check("count",     {29'd0, count},         32'(mq.size()));
        check("enq_ready", {31'd0, bus.enq_ready}, {31'd0, mq.size() < 4});
        check("hazard1",   {31'd0, hazard1},       {31'd0, h1});
        check("hazard2",   {31'd0, hazard2},       {31'd0, h2});
        check("fwd_data1", fwd_data1,              f1);
        check("fwd_data2", fwd_data2,              f2);
    endtask

    // One clock cycle: drive at negedge, check, then advance the model past the next edge.
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic [4:0] c1, input logic [4:0] c2);
        logic accepted;
        ent_t e;
        @(negedge clk);
        bus.enq_valid = v;
        bus.enq_addr  = a;
        bus.enq_data  = d;
        chk_addr1     = c1;
        chk_addr2     = c2;
        #1;
        check_model();
        accepted = v && (mq.size() < 4);
        if (mq.size() != 0) void'(mq.pop_front());
        if (accepted && a != 5'd0) begin
            e.a = a;
            e.d = d;
            mq.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.enq_valid = 1'b0;
        #2 RST = 1'b0;
        #1;
        check("rst_wr_en",     {31'd0, bus.wr_en},     32'd0);
        check("rst_count",     {29'd0, count},         32'd0);
        check("rst_enq_ready", {31'd0, bus.enq_ready}, 32'd1);
        check("rst_hazard1",   {31'd0, hazard1},       32'd0);
        check("rst_hazard2",   {31'd0, hazard2},       32'd0);
        check("rst_fwd_data1", fwd_data1,              32'd0);
        mq.delete();
        @(negedge clk);
        check("rst_hold_wr_en", {31'd0, bus.wr_en}, 32'd0);
        RST = 1'b1;
    endtask

    initial begin
        logic [4:0]  ra, last_a, c1, c2;
        logic [31:0] rd;
        logic        rv;
        RST = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_addr  = 5'd0;
        bus.enq_data  = 32'd0;
        chk_addr1 = 5'd0;
        chk_addr2 = 5'd0;
        last_a = 5'd1;
        #3;
        check("reset_wr_en",     {31'd0, bus.wr_en},     32'd0);
        check("reset_wr_addr",   {27'd0, bus.wr_addr},   32'd0);
        check("reset_wr_data",   bus.wr_data,            32'd0);
        check("reset_count",     {29'd0, count},         32'd0);
        check("reset_enq_ready", {31'd0, bus.enq_ready}, 32'd1);
        @(negedge clk);
        RST = 1'b1;

        // Single write into empty queue.
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        check("single_wr_en",   {31'd0, bus.wr_en}, 32'd1);
        check("single_wr_data", bus.wr_data,        32'hDEADBEEF);
        check("single_hazard",  {31'd0, hazard1},   32'd1);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        check("single_done_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("single_done_count", {29'd0, count},     32'd0);

        // Back-to-back fill and a longer burst.
        for (int i = 0; i < 4; i++) step(1'b1, 5'(10 + i), $urandom, 5'(10 + i), 5'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 5'(20 + i), $urandom, 5'(19 + i), 5'(20 + i));
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // $zero write is accepted but dropped.
        step(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        check("zero_ready", {31'd0, bus.enq_ready}, 32'd1);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("zero_count",   {29'd0, count},     32'd0);
        check("zero_wr_en",   {31'd0, bus.wr_en}, 32'd0);
        check("zero_hazard1", {31'd0, hazard1},   32'd0);

        // Hazards on 7 then 9, each clearing after its pop.
        step(1'b1, 5'd7, 32'h77, 5'd7, 5'd9);
        step(1'b1, 5'd9, 32'h99, 5'd7, 5'd9);
        check("haz7_set", {31'd0, hazard1}, 32'd1);
        step(1'b0, 5'd0, 32'h0, 5'd7, 5'd9);
        check("haz7_clr", {31'd0, hazard1}, 32'd0);
        check("haz9_set", {31'd0, hazard2}, 32'd1);
        step(1'b0, 5'd0, 32'h0, 5'd7, 5'd9);
        check("haz9_clr", {31'd0, hazard2}, 32'd0);

        // Forwarding of the youngest matching entry.
        step(1'b1, 5'd3, 32'h11, 5'd3, 5'd0);
        step(1'b1, 5'd3, 32'h22, 5'd3, 5'd0);
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
`ifdef WBQ_FORWARD_EN
        check("fwd_youngest", fwd_data1, 32'h22);
`else
        check("fwd_off", fwd_data1, 32'h0);
`endif
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);

        // Random traffic with a reset in the middle.
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rd = $urandom;
            c1 = ($urandom_range(0, 1) != 0) ? last_a : 5'($urandom_range(0, 31));
            c2 = ($urandom_range(0, 1) != 0) ? ra : 5'($urandom_range(0, 31));
            step(rv, ra, rd, c1, c2);
            if (rv && ra != 5'd0) last_a = ra;
            if (n == 200) begin
                step(1'b1, 5'd17, 32'hCAFE0017, 5'd17, 5'd0);
                chk_addr1 = 5'd17;
                do_reset();
                step(1'b0, 5'd0, 32'h0, 5'd17, 5'd0);
                check("post_rst_no_write", {31'd0, bus.wr_en}, 32'd0);
            end
        end
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
